uart_tx_feeder: RTL

- Byte-buffering front end that sits directly upstream of the UART transmitter and drives its enable and parallel data inputs.
- Accepts bytes from the system side into a circular FIFO.
- Launches each byte as a one-cycle enable pulse plus stable data, then tracks the transmitter's active flag until the frame completes.
- Issues the next byte only after the frame completes; a start timeout guards against a transmitter that never responds.

---
 rtl/uart_tx_feeder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: launches one byte per frame as a single
// tx_en pulse with held data, then tracks tx_active until the frame completes.
module uart_tx_feeder #(
  parameter int unsigned AW            = 4,
  parameter int unsigned START_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          err_clr,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          start_err,
  output logic          busy,
  output logic          tx_en,
  output logic [7:0]    tx_data,
  input  logic          tx_active
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned TW    = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    WAIT_DONE
  } state_t;

  logic [7:0]    mem [DEPTH];

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   level_q, level_d;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          tx_en_q, tx_en_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          overflow_q, overflow_d;
  logic          start_err_q, start_err_d;

  logic          full_w;
  logic          wr_accept;
  logic          wr_drop;
  logic          pop;
  logic          timeout_evt;

  // Full comes from the registered level, so a pop on the same edge cannot
  // make room for a write that arrived while full.
  assign full_w    = (level_q == (AW+1)'(DEPTH));
  assign wr_accept = wr_en && !full_w;
  assign wr_drop   = wr_en && full_w;

  always_comb begin
    wp_d    = wp_q;
    level_d = level_q;
    if (wr_accept) begin
      wp_d = wp_q + AW'(1);
    end
    level_d = level_q + (AW+1)'(wr_accept) - (AW+1)'(pop);
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    tx_en_d     = 1'b0;
    tx_data_d   = tx_data_q;
    rp_d        = rp_q;
    pop         = 1'b0;
    timeout_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((level_q != '0) && !tx_active) begin
          pop       = 1'b1;
          tx_data_d = mem[rp_q];
          rp_d      = rp_q + AW'(1);
          tx_en_d   = 1'b1;
          timer_d   = '0;
          state_d   = WAIT_START;
        end
      end
      WAIT_START: begin
        if (tx_active) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
          timeout_evt = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_active) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A set event on the same edge as err_clr keeps the flag high.
  always_comb begin
    overflow_d  = overflow_q;
    start_err_d = start_err_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      start_err_d = 1'b0;
    end
    if (wr_drop) begin
      overflow_d = 1'b1;
    end
    if (timeout_evt) begin
      start_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q        <= '0;
      rp_q        <= '0;
      level_q     <= '0;
      state_q     <= IDLE;
      timer_q     <= '0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= '0;
      overflow_q  <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      level_q     <= level_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
      overflow_q  <= overflow_d;
      start_err_q <= start_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wp_q] <= wr_data;
    end
  end

  assign full      = full_w;
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign start_err = start_err_q;
  assign busy      = (state_q != IDLE);
  assign tx_en     = tx_en_q;
  assign tx_data   = tx_data_q;

  a_tx_en_single: assert property (@(posedge clk) disable iff (!rst_n)
    tx_en_q |=> !tx_en_q);
  a_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |=> $stable(tx_data_q));
  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
    level_q <= (AW+1)'(DEPTH));

endmodule
